// File: rtl/cpu_run_ctl.sv
// Run/step/halt controller for the nic8 CPU: produces the CPU clock enable,
// stops at instruction boundaries, and gives a debug/DMA port the RAM while halted.
module cpu_run_ctl #(
  parameter bit RUN_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_req,
  input  logic       step_req,
  input  logic       halt_req,
  input  logic       bp_en,
  input  logic [7:0] bp_addr,
  input  logic [7:0] pc,
  input  logic       ir_load,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       dma_req,
  input  logic       dma_we,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  input  logic [7:0] ram_rdata,
  output logic       cpu_en,
  output logic       mem_sel,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       dma_ack,
  output logic [7:0] dma_rdata,
  output logic       halted,
  output logic       bp_hit,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DMA  = 2'd3
  } state_t;

  localparam state_t RESET_STATE = RUN_ON_RESET ? ST_RUN : ST_HALT;

  state_t      state_q, state_d;
  logic        first_q, first_d;
  logic        halt_pend_q, halt_pend_d;
  logic        bp_hit_q, bp_hit_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic [7:0]  dma_rdata_q, dma_rdata_d;

  logic active;
  logic bp_match;
  logic step_end;
  logic stop;
  logic fetch;

  // first masks the breakpoint and step-end terms so the fetch a run or step
  // resumes at is always allowed through.
  always_comb begin
    active   = (state_q == ST_RUN) || (state_q == ST_STEP);
    bp_match = !first_q && bp_en && (pc == bp_addr);
    step_end = (state_q == ST_STEP) && !first_q;
    stop     = ir_load && (halt_pend_q || bp_match || step_end);
    cpu_en   = active && !stop;
    fetch    = ir_load && cpu_en;
  end

  always_comb begin
    state_d       = state_q;
    first_d       = first_q;
    halt_pend_d   = halt_pend_q;
    bp_hit_d      = bp_hit_q;
    dma_rdata_d   = dma_rdata_q;
    instr_count_d = fetch ? instr_count_q + 16'd1 : instr_count_q;

    case (state_q)
      ST_HALT: begin
        if (dma_req) begin
          state_d = ST_DMA;
        end else if (step_req) begin
          state_d  = ST_STEP;
          first_d  = 1'b1;
          bp_hit_d = 1'b0;
        end else if (run_req) begin
          state_d  = ST_RUN;
          first_d  = 1'b1;
          bp_hit_d = 1'b0;
        end
      end
      ST_RUN, ST_STEP: begin
        // A halt request landing on the stopping fetch itself is dropped.
        if (stop) begin
          state_d     = ST_HALT;
          halt_pend_d = 1'b0;
          if (bp_match) begin
            bp_hit_d = 1'b1;
          end
        end else begin
          if (halt_req) begin
            halt_pend_d = 1'b1;
          end
          if (fetch) begin
            first_d = 1'b0;
          end
        end
      end
      ST_DMA: begin
        state_d     = ST_HALT;
        dma_rdata_d = ram_rdata;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RESET_STATE;
      first_q       <= 1'b1;
      halt_pend_q   <= 1'b0;
      bp_hit_q      <= 1'b0;
      instr_count_q <= 16'h0000;
      dma_rdata_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      halt_pend_q   <= halt_pend_d;
      bp_hit_q      <= bp_hit_d;
      instr_count_q <= instr_count_d;
      dma_rdata_q   <= dma_rdata_d;
    end
  end

  always_comb begin
    mem_sel = (state_q == ST_DMA);
    dma_ack = mem_sel;
    if (mem_sel) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we && cpu_en;
    end
  end

  assign halted      = (state_q == ST_HALT);
  assign bp_hit      = bp_hit_q;
  assign instr_count = instr_count_q;
  assign dma_rdata   = dma_rdata_q;

endmodule

// File: tb/tb_cpu_run_ctl.sv
// Bench for cpu_run_ctl: a tiny CPU/RAM environment, a behavioural model of
// the run controller, directed scenarios and a randomized soak.
module tb_cpu_run_ctl;

  localparam int MODE_HALT = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_STEP = 2;
  localparam int MODE_DMA  = 3;

  logic        clk;
  logic        reset;
  logic        run_req, step_req, halt_req;
  logic        bp_en;
  logic [7:0]  bp_addr, pc;
  logic        ir_load;
  logic        cpu_we;
  logic [7:0]  cpu_addr, cpu_wdata;
  logic        dma_req, dma_we;
  logic [7:0]  dma_addr, dma_wdata;
  logic [7:0]  ram_rdata;
  logic        cpu_en, mem_sel, mem_we, dma_ack, halted, bp_hit;
  logic [7:0]  mem_addr, mem_wdata, dma_rdata;
  logic [15:0] instr_count;

  logic        r_cpu_en, r_mem_sel, r_mem_we, r_dma_ack, r_halted, r_bp_hit;
  logic [7:0]  r_mem_addr, r_mem_wdata, r_dma_rdata;
  logic [15:0] r_instr_count;

  logic [7:0] ram [256] = '{default: 8'h00};

  cpu_run_ctl #(.RUN_ON_RESET(1'b0)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .ir_load(ir_load), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .ram_rdata(ram_rdata),
    .cpu_en(cpu_en), .mem_sel(mem_sel), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dma_ack(dma_ack),
    .dma_rdata(dma_rdata), .halted(halted), .bp_hit(bp_hit),
    .instr_count(instr_count)
  );

  // Default-parameter instance, only observed around resets.
  cpu_run_ctl dut_r (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .ir_load(ir_load), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .ram_rdata(ram_rdata),
    .cpu_en(r_cpu_en), .mem_sel(r_mem_sel), .mem_we(r_mem_we),
    .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .dma_ack(r_dma_ack),
    .dma_rdata(r_dma_rdata), .halted(r_halted), .bp_hit(r_bp_hit),
    .instr_count(r_instr_count)
  );

  assign ram_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: controller mode plus fetches done since the last start.
  int         m_mode = MODE_HALT;
  int         m_fetches = 0;
  bit         m_pend = 1'b0;
  bit         m_bp = 1'b0;
  int         m_count = 0;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] m_mem [256] = '{default: 8'h00};

  // CPU environment: instruction of env_len cycles, fetch on cycle 0.
  int         env_cyc = 0;
  int         env_len = 2;
  logic [7:0] env_pc = 8'h00;
  bit         rand_len = 1'b0;

  bit e_en, e_halt_now, e_at_bp, e_dma;
  bit check_on, check_r;
  logic       obs_en, obs_ack, obs_sel, obs_we, obs_halted;
  logic [7:0] obs_addr;
  logic [15:0] obs_count;
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic predict();
    bit running;
    running    = (m_mode == MODE_RUN) || (m_mode == MODE_STEP);
    e_at_bp    = bp_en && (pc == bp_addr) && (m_fetches > 0);
    e_halt_now = ir_load && (m_pend || e_at_bp ||
                             ((m_mode == MODE_STEP) && (m_fetches > 0)));
    e_en       = running && !e_halt_now;
    e_dma      = (m_mode == MODE_DMA);
  endtask

  task automatic checkOutput();
    predict();
    obs_en = cpu_en; obs_ack = dma_ack; obs_sel = mem_sel; obs_we = mem_we;
    obs_addr = mem_addr; obs_halted = halted; obs_count = instr_count;
    if (!check_on) return;
    chk("cpu_en", 16'(cpu_en), 16'(e_en));
    chk("halted", 16'(halted), 16'(m_mode == MODE_HALT));
    chk("dma_ack", 16'(dma_ack), 16'(e_dma));
    chk("mem_sel", 16'(mem_sel), 16'(e_dma));
    chk("mem_we", 16'(mem_we), 16'(e_dma ? dma_we : (cpu_we && e_en)));
    chk("mem_addr", 16'(mem_addr), 16'(e_dma ? dma_addr : cpu_addr));
    chk("mem_wdata", 16'(mem_wdata), 16'(e_dma ? dma_wdata : cpu_wdata));
    chk("bp_hit", 16'(bp_hit), 16'(m_bp));
    chk("instr_count", instr_count, 16'(m_count));
    chk("dma_rdata", 16'(dma_rdata), 16'(m_rdata));
    if (check_r) begin
      chk("r_cpu_en", 16'(r_cpu_en), 16'd1);
      chk("r_halted", 16'(r_halted), 16'd0);
      chk("r_dma_ack", 16'(r_dma_ack), 16'd0);
      chk("r_mem_sel", 16'(r_mem_sel), 16'd0);
      chk("r_mem_we", 16'(r_mem_we), 16'(cpu_we));
      chk("r_mem_addr", 16'(r_mem_addr), 16'(cpu_addr));
      chk("r_mem_wdata", 16'(r_mem_wdata), 16'(cpu_wdata));
      chk("r_bp_hit", 16'(r_bp_hit), 16'd0);
      chk("r_instr_count", r_instr_count, 16'd0);
      chk("r_dma_rdata", 16'(r_dma_rdata), 16'd0);
    end
  endtask

  task automatic modelUpdate();
    predict();
    if (!reset) begin
      m_mode = MODE_HALT; m_fetches = 0; m_pend = 0; m_bp = 0;
      m_count = 0; m_rdata = 8'h00;
      env_pc = 8'h00; env_cyc = 0; env_len = 2;
      return;
    end
    if (e_en) begin
      if (cpu_we) m_mem[cpu_addr] = cpu_wdata;
      if (ir_load) begin
        m_count = (m_count + 1) % 65536;
        env_pc  = env_pc + 8'd1;
      end
      if (env_cyc == env_len - 1) begin
        env_cyc = 0;
        env_len = rand_len ? int'($urandom_range(2, 3)) : 2;
      end else begin
        env_cyc++;
      end
    end
    case (m_mode)
      MODE_HALT: begin
        if (dma_req) m_mode = MODE_DMA;
        else if (step_req || run_req) begin
          m_mode = step_req ? MODE_STEP : MODE_RUN;
          m_fetches = 0;
          m_bp = 0;
        end
      end
      MODE_RUN, MODE_STEP: begin
        if (e_halt_now) begin
          m_mode = MODE_HALT;
          m_pend = 0;
          if (e_at_bp) m_bp = 1;
        end else begin
          if (halt_req) m_pend = 1;
          if (ir_load) m_fetches++;
        end
      end
      default: begin
        m_rdata = m_mem[dma_addr];
        if (dma_we) m_mem[dma_addr] = dma_wdata;
        m_mode = MODE_HALT;
      end
    endcase
  endtask

  task automatic applyStimulus(input bit run, input bit step, input bit halt,
                               input bit dreq, input bit dwe,
                               input logic [7:0] daddr, input logic [7:0] dwdata);
    run_req = run; step_req = step; halt_req = halt;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwdata;
    ir_load = (env_cyc == 0);
    pc = env_pc;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int en_cycles, acks;
    bit got_ack;
    reset = 0; run_req = 0; step_req = 0; halt_req = 0; bp_en = 0; bp_addr = 0;
    pc = 0; ir_load = 1; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    check_on = 0; check_r = 0;
    idle();
    check_on = 1; check_r = 1;
    idle();
    check_r = 0;
    reset = 1;
    chk("reset_halted", 16'(halted), 16'd1);
    chk("reset_count", instr_count, 16'd0);

    // Single step of a 2-cycle instruction.
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00);
    en_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      en_cycles += int'(obs_en);
    end
    chk("step_en_cycles", 16'(en_cycles), 16'd2);
    chk("step_count", instr_count, 16'd1);
    chk("step_halted", 16'(halted), 16'd1);

    // Breakpoint at 0x05, then resume through it.
    bp_en = 1; bp_addr = 8'h05;
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 60; i++) begin
      idle();
      if (halted) break;
    end
    chk("bp_halted", 16'(halted), 16'd1);
    chk("bp_flag", 16'(bp_hit), 16'd1);
    chk("bp_count", instr_count, 16'd5);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 8'h00);
    idle();
    chk("resume_fetch_en", 16'(obs_en), 16'd1);
    idle();
    chk("resume_count", instr_count, 16'd6);
    chk("resume_bp_clear", 16'(bp_hit), 16'd0);

    // Halt request in an execute cycle waits for the next fetch.
    idle();
    applyStimulus(0, 0, 1, 0, 0, 8'h00, 8'h00);
    chk("midhalt_exec_en", 16'(obs_en), 16'd1);
    idle();
    chk("midhalt_stop_en", 16'(obs_en), 16'd0);
    chk("midhalt_halted", 16'(halted), 16'd1);
    chk("midhalt_count", instr_count, 16'd7);
    bp_en = 0;

    // DMA write then read while halted, CPU store attempt ignored.
    cpu_we = 1; cpu_addr = 8'h33; cpu_wdata = 8'h5A;
    applyStimulus(0, 0, 0, 1, 1, 8'h10, 8'hA5);
    chk("halt_cpu_we_blocked", 16'(obs_we), 16'd0);
    applyStimulus(0, 0, 0, 1, 1, 8'h10, 8'hA5);
    chk("dmaw_ack", 16'(obs_ack), 16'd1);
    chk("dmaw_sel", 16'(obs_sel), 16'd1);
    chk("dmaw_addr", 16'(obs_addr), 16'h0010);
    chk("dmaw_we", 16'(obs_we), 16'd1);
    idle();
    chk("dmaw_ack_once", 16'(obs_ack), 16'd0);
    cpu_we = 0;
    applyStimulus(0, 0, 0, 1, 0, 8'h10, 8'h00);
    applyStimulus(0, 0, 0, 1, 0, 8'h10, 8'h00);
    chk("dmar_ack", 16'(obs_ack), 16'd1);
    chk("dmar_we", 16'(obs_we), 16'd0);
    chk("dmar_addr", 16'(obs_addr), 16'h0010);
    idle();
    chk("dmar_rdata", 16'(dma_rdata), 16'h00A5);

    // DMA request held through a run is deferred to HALT.
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 8'h00);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 8'h20, 8'h00);
      acks += int'(obs_ack);
    end
    chk("run_no_ack", 16'(acks), 16'd0);
    got_ack = 0;
    applyStimulus(0, 0, 1, 1, 0, 8'h20, 8'h00);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 8'h20, 8'h00);
      if (obs_ack) begin
        got_ack = 1;
        break;
      end
    end
    chk("deferred_ack", 16'(got_ack), 16'd1);
    idle();

    // DMA and step together: DMA first, then the step.
    applyStimulus(0, 1, 0, 1, 0, 8'h10, 8'h00);
    applyStimulus(0, 1, 0, 1, 0, 8'h10, 8'h00);
    chk("both_dma_first", 16'(obs_ack), 16'd1);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00);
    idle();
    chk("both_step_en", 16'(obs_en), 16'd1);
    chk("both_step_running", 16'(obs_halted), 16'd0);
    for (int i = 0; i < 4; i++) idle();

    // Reset during a DMA cycle.
    applyStimulus(0, 0, 0, 1, 1, 8'h40, 8'h77);
    reset = 0;
    applyStimulus(0, 0, 0, 1, 1, 8'h40, 8'h77);
    reset = 1;
    check_r = 1;
    idle();
    check_r = 0;
    chk("rst_dma_ack", 16'(obs_ack), 16'd0);
    chk("rst_dma_count", obs_count, 16'd0);
    chk("rst_dma_halted", 16'(obs_halted), 16'd1);

    // Reset during RUN with instr_count at 0x0123.
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 1500; i++) begin
      if (m_count == 'h123) break;
      idle();
    end
    chk("pre_rst_count", instr_count, 16'h0123);
    reset = 0;
    idle();
    reset = 1;
    cpu_we = 1; cpu_addr = 8'h44; cpu_wdata = 8'h99;
    check_r = 1;
    idle();
    check_r = 0;
    cpu_we = 0;
    chk("rst_run_count", obs_count, 16'd0);
    chk("rst_run_halted", 16'(obs_halted), 16'd1);
    chk("rst_run_en", 16'(obs_en), 16'd0);

    // Randomized soak against the model.
    rand_len = 1;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) begin
        bp_en = ~bp_en;
        bp_addr = env_pc + 8'($urandom_range(0, 6));
      end
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 8'($urandom_range(0, 15));
      cpu_wdata = 8'($urandom);
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                    8'($urandom));
    end
    reset = 1;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
